uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
UART transmit framer, the transmit-side counterpart of the receive ErrorCheck block. It accepts one data word per valid/ready handshake and serialises it LSB-first as start bit, data bits, optional parity bit and stop bit(s). It generates parity with the same parity_type encoding that ErrorCheck checks. It has an internal baud-rate counter and drives the serial line directly.

Parameters:
DATA_BITS, 8, data word width (5..9).
PARITY_EN, 1, 1 = parity bit may be inserted; 0 = parity bit never sent, parity_type ignored.
STOP_BITS, 1, number of stop bits (1 or 2).
CLKS_PER_BIT, 16, clk cycles per serial bit (>=2).

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
tx_valid  input  1  raw_data/parity_type valid; a frame is requested.
tx_ready  output  1  block can accept a word (high only in IDLE).
raw_data  input  DATA_BITS  word to transmit.
parity_type  input  2  2'b01 odd, 2'b10 even, 2'b00/2'b11 no parity bit.
tx  output  1  serial line; idle high.
tx_busy  output  1  high while a frame is on the line.
tx_done  output  1  one-cycle pulse when a frame completes.

Behaviour:
- Reset (synchronous, sampled on clk edge with reset=1): state IDLE, tx=1, tx_busy=0, tx_done=0, tx_ready=1, bit and baud counters 0. Reset takes effect mid-frame: tx returns high at that edge. The frame is abandoned and no tx_done pulse is produced. Handshakes are ignored while reset=1.
- Handshake: the word is accepted on an edge where tx_valid && tx_ready. raw_data and parity_type are latched at that edge. Later input changes do not affect the frame in flight. tx_ready = (state==IDLE), so it is low from the cycle after acceptance until the frame ends.
- Parity is computed from the latched data. Even: p = ^data. Odd: p = ~^data. A parity bit is sent only when PARITY_EN=1 and the latched parity_type is 01 or 10.
- FSM states and transitions:
  - IDLE: tx=1. On handshake, go to START.
  - START: tx=0.
  - DATA: tx=data[bit_idx], with bit_idx going 0..DATA_BITS-1.
  - PARITY: tx=p. This state is skipped when no parity bit is sent.
  - STOP: tx=1, repeated STOP_BITS times.
  - After the final STOP bit, return to IDLE.
- Every bit state holds tx for exactly CLKS_PER_BIT cycles. The baud counter counts 0..CLKS_PER_BIT-1, then wraps to 0 and the state advances.
- Latency: tx falls on the first cycle after the accepting edge.
- Frame length: N = 1 + DATA_BITS + P + STOP_BITS bits, where P is 0 or 1. The line is non-idle for N*CLKS_PER_BIT cycles.
- tx_busy is high from the START state through the last STOP cycle.
- On the cycle the FSM re-enters IDLE, tx_done=1 for exactly one cycle and tx_ready=1 in that same cycle.
- Back-to-back: if tx_valid is held high, the next word is accepted in that IDLE cycle. Consecutive frames are therefore separated by exactly one extra idle-high clock. There are no other gaps.
- tx is registered and glitch-free: it changes only on clk edges at bit boundaries.
- Width rules: the bit counter is sized for DATA_BITS. The baud counter is sized clog2(CLKS_PER_BIT).

Test Plan:
- DATA_BITS=8, CLKS_PER_BIT=4, PARITY_EN=1, parity_type=2'b10, raw_data=8'h55.
  - Required: tx sequence 0,1,0,1,0,1,0,1,0,0,1, each bit held 4 clocks.
  - Required: the 44-cycle frame starts 1 cycle after the handshake.
  - Required: tx_done pulses once at cycle 45 after acceptance, and ErrorCheck reports 3'b000 on the looped-back frame.
- Same raw_data=8'h55 with parity_type=2'b01:
  - Required: parity bit = 1.
  - Required: parity_type=2'b00 gives a 10-bit frame (40 cycles) with no parity bit.
- tx_valid held high with words 8'hA3 then 8'h0F:
  - Required: the second start bit begins exactly 1 idle clock after the first frame's stop bit ends.
  - Required: tx_ready is high only in that single cycle.
  - Required: inputs changed mid-frame do not alter the bits on the line.
- Assert reset during DATA bit 3 of a frame:
  - Required: tx=1, tx_busy=0, tx_ready=1 at the next edge, with no tx_done.
  - Required: a new handshake after reset is released produces a full, correct frame.
- STOP_BITS=2, PARITY_EN=0, DATA_BITS=7, raw_data=7'h7F, parity_type=2'b10:
  - Required: 10-bit frame 0,1,1,1,1,1,1,1,1,1 with no parity bit.
  - Required: tx_busy high for 10*CLKS_PER_BIT cycles.

Source files
------------

// File: rtl/uart_tx_frame.sv
// UART transmit framer: accepts one word per valid/ready handshake and serialises it
// LSB-first as start, data, optional parity and stop bits at CLKS_PER_BIT clocks per bit.
module uart_tx_frame #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  input  logic [DATA_BITS-1:0] i_raw_data,
  input  logic [1:0]           i_parity_type,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam int unsigned BitW  = $clog2(DATA_BITS);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0]  DataLast = BitW'(DATA_BITS - 1);
  localparam logic [BitW-1:0]  StopLast = BitW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e               r_state;
  logic [BaudW-1:0]     r_baud;
  logic [BitW-1:0]      r_bit;
  logic [DATA_BITS-1:0] r_data;
  logic [DATA_BITS-1:0] r_shift;
  logic [1:0]           r_ptype;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;

  logic w_bit_end;
  logic w_par_send;
  logic w_par_bit;

  assign w_bit_end  = (r_baud == BaudLast);
  assign w_par_send = (PARITY_EN != 0) && ((r_ptype == 2'b01) || (r_ptype == 2'b10));
  // 2'b01 selects odd parity, anything else that reaches here is even.
  assign w_par_bit  = (r_ptype == 2'b01) ? ~^r_data : ^r_data;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_baud  <= '0;
      r_bit   <= '0;
      r_data  <= '0;
      r_shift <= '0;
      r_ptype <= 2'b00;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state != StIdle) begin
        r_baud <= w_bit_end ? '0 : r_baud + 1'b1;
      end
      unique case (r_state)
        StIdle: begin
          if (i_tx_valid) begin
            r_state <= StStart;
            r_tx    <= 1'b0;
            r_busy  <= 1'b1;
            r_data  <= i_raw_data;
            r_shift <= i_raw_data;
            r_ptype <= i_parity_type;
            r_baud  <= '0;
            r_bit   <= '0;
          end
        end
        StStart: begin
          if (w_bit_end) begin
            r_state <= StData;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end
        end
        StData: begin
          if (w_bit_end) begin
            if (r_bit == DataLast) begin
              r_bit <= '0;
              if (w_par_send) begin
                r_state <= StParity;
                r_tx    <= w_par_bit;
              end else begin
                r_state <= StStop;
                r_tx    <= 1'b1;
              end
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end
        end
        StParity: begin
          if (w_bit_end) begin
            r_state <= StStop;
            r_tx    <= 1'b1;
            r_bit   <= '0;
          end
        end
        StStop: begin
          if (w_bit_end) begin
            if (r_bit == StopLast) begin
              r_state <= StIdle;
              r_bit   <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end
        end
        default: begin
          r_state <= StIdle;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_ready = (r_state == StIdle);
  assign o_tx       = r_tx;
  assign o_tx_busy  = r_busy;
  assign o_tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: a driver pushes model frames, per-DUT monitors
// reconstruct the serial line and compare against them.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  typedef struct {
    int bits;
    int len;
    int t;
  } frame_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // DUT A: 8 data bits, parity allowed, 1 stop bit.
  logic       a_rst, a_valid, a_ready, a_tx, a_busy, a_done;
  logic [7:0] a_data;
  logic [1:0] a_pt;
  // DUT B: 7 data bits, no parity, 2 stop bits.
  logic       b_rst, b_valid, b_ready, b_tx, b_busy, b_done;
  logic [6:0] b_data;
  logic [1:0] b_pt;

  uart_tx_frame #(.DATA_BITS(8), .PARITY_EN(1), .STOP_BITS(1), .CLKS_PER_BIT(CPB)) dut_a (
    .i_clk(clk), .i_reset(a_rst), .i_tx_valid(a_valid), .o_tx_ready(a_ready),
    .i_raw_data(a_data), .i_parity_type(a_pt), .o_tx(a_tx), .o_tx_busy(a_busy),
    .o_tx_done(a_done)
  );

  uart_tx_frame #(.DATA_BITS(7), .PARITY_EN(0), .STOP_BITS(2), .CLKS_PER_BIT(CPB)) dut_b (
    .i_clk(clk), .i_reset(b_rst), .i_tx_valid(b_valid), .o_tx_ready(b_ready),
    .i_raw_data(b_data), .i_parity_type(b_pt), .o_tx(b_tx), .o_tx_busy(b_busy),
    .o_tx_done(b_done)
  );

  int     n_vec = 0;
  int     n_bad = 0;
  frame_t q0[$];
  frame_t q1[$];
  int     mon_act[2];
  int     last_t, last_end;

  task automatic chk(input int id, input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL dut%0d %s: got %0d, want %0d (cycle %0d)", id, name, act, exp, cyc);
    end
  endtask

  function automatic logic txv(input int id);
    return (id == 0) ? a_tx : b_tx;
  endfunction
  function automatic logic busyv(input int id);
    return (id == 0) ? a_busy : b_busy;
  endfunction
  function automatic logic donev(input int id);
    return (id == 0) ? a_done : b_done;
  endfunction
  function automatic logic rdyv(input int id);
    return (id == 0) ? a_ready : b_ready;
  endfunction
  function automatic logic rstv(input int id);
    return (id == 0) ? a_rst : b_rst;
  endfunction

  // Reference frame: list of line levels built straight from the framing rules.
  function automatic frame_t model(input int id, input int data, input int pt);
    frame_t f;
    int dbits, pe, stops, ones, pos;
    dbits = (id == 0) ? 8 : 7;
    pe    = (id == 0) ? 1 : 0;
    stops = (id == 0) ? 1 : 2;
    f.bits = 0;
    pos = 1;
    ones = 0;
    for (int i = 0; i < dbits; i++) begin
      f.bits |= ((data >> i) & 1) << pos;
      ones += (data >> i) & 1;
      pos++;
    end
    if (pe == 1 && (pt == 1 || pt == 2)) begin
      f.bits |= ((pt == 2) ? (ones % 2) : (1 - ones % 2)) << pos;
      pos++;
    end
    for (int i = 0; i < stops; i++) begin
      f.bits |= 1 << pos;
      pos++;
    end
    f.len = pos;
    f.t = 0;
    return f;
  endfunction

  task automatic send(input int id, input int data, input int pt, input bit keep,
                      input bit btb);
    frame_t f;
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!rdyv(id) && w < 500);
    if (!rdyv(id)) begin
      chk(id, "ready timeout", 0, 1);
      return;
    end
    if (btb) chk(id, "back-to-back accept cycle", cyc, last_end);
    f = model(id, data, pt);
    f.t = btb ? last_end + 1 : cyc + 1;
    last_t = f.t;
    last_end = f.t + f.len * CPB;
    if (id == 0) begin
      a_valid = 1'b1; a_data = 8'(data); a_pt = 2'(pt); q0.push_back(f);
    end else begin
      b_valid = 1'b1; b_data = 7'(data); b_pt = 2'(pt); q1.push_back(f);
    end
    @(posedge clk);
    #1;
    // Scramble inputs mid-frame; the latched word must not change.
    if (id == 0) begin
      a_valid = keep; a_data = 8'($urandom); a_pt = 2'($urandom);
    end else begin
      b_valid = keep; b_data = 7'($urandom); b_pt = 2'($urandom);
    end
  endtask

  task automatic monitor(input int id);
    frame_t e;
    int cap, hold, bb, br, bd, ab, w;
    forever begin
      @(negedge clk);
      if (rstv(id) !== 1'b0) continue;
      if (txv(id) !== 1'b0) continue;
      if ((id == 0 ? q0.size() : q1.size()) == 0) begin
        chk(id, "unexpected frame", 1, 0);
        w = 0;
        while (txv(id) !== 1'b1 && w < 200) begin
          @(negedge clk);
          w++;
        end
        continue;
      end
      e = (id == 0) ? q0.pop_front() : q1.pop_front();
      mon_act[id] = 1;
      chk(id, "start cycle", cyc, e.t);
      cap = 0; hold = 0; bb = 0; br = 0; bd = 0; ab = 0;
      for (int k = 0; k < e.len * CPB; k++) begin
        if (k > 0) begin
          @(negedge clk);
          if (rstv(id) !== 1'b0) begin
            ab = 1;
            break;
          end
        end
        if (k % CPB == 0) cap |= int'(txv(id) === 1'b1) << (k / CPB);
        else if (int'(txv(id) === 1'b1) != ((cap >> (k / CPB)) & 1)) hold++;
        if (busyv(id) !== 1'b1) bb++;
        if (rdyv(id) !== 1'b0) br++;
        if (donev(id) !== 1'b0) bd++;
      end
      if (!ab) begin
        chk(id, "frame bits", cap, e.bits);
        chk(id, "bit hold glitches", hold, 0);
        chk(id, "busy low in frame", bb, 0);
        chk(id, "ready high in frame", br, 0);
        chk(id, "done high in frame", bd, 0);
        @(negedge clk);
        if (rstv(id) === 1'b0) begin
          chk(id, "done at frame end", int'(donev(id)), 1);
          chk(id, "ready at frame end", int'(rdyv(id)), 1);
          chk(id, "busy at frame end", int'(busyv(id)), 0);
          chk(id, "tx idle at frame end", int'(txv(id)), 1);
        end
      end
      mon_act[id] = 0;
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial begin
    bit prev_keep, keep;
    int w;
    mon_act[0] = 0; mon_act[1] = 0;
    a_rst = 1'b1; a_valid = 1'b0; a_data = '0; a_pt = '0;
    b_rst = 1'b1; b_valid = 1'b0; b_data = '0; b_pt = '0;
    repeat (3) @(negedge clk);
    chk(0, "reset tx", int'(a_tx), 1);
    chk(0, "reset busy", int'(a_busy), 0);
    chk(0, "reset done", int'(a_done), 0);
    chk(0, "reset ready", int'(a_ready), 1);
    chk(1, "reset tx", int'(b_tx), 1);
    chk(1, "reset busy", int'(b_busy), 0);
    chk(1, "reset ready", int'(b_ready), 1);
    @(posedge clk);
    #1;
    a_rst = 1'b0; b_rst = 1'b0;

    send(0, 'h55, 2'b10, 1'b0, 1'b0);
    send(0, 'h55, 2'b01, 1'b0, 1'b0);
    send(0, 'h55, 2'b00, 1'b0, 1'b0);
    send(0, 'h55, 2'b11, 1'b0, 1'b0);
    send(0, 'hA3, 2'b10, 1'b1, 1'b0);
    send(0, 'h0F, 2'b01, 1'b0, 1'b1);

    prev_keep = 1'b0;
    for (int i = 0; i < 10; i++) begin
      keep = (i == 9) ? 1'b0 : 1'($urandom);
      send(0, int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), keep, prev_keep);
      prev_keep = keep;
    end

    // Abort a frame during data bit 3.
    send(0, int'($urandom_range(0, 255)), 2'b10, 1'b0, 1'b0);
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (cyc != last_t + 4 * CPB + 1 && w < 500);
    @(posedge clk);
    #1;
    a_rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk(0, "mid-frame reset tx", int'(a_tx), 1);
    chk(0, "mid-frame reset busy", int'(a_busy), 0);
    chk(0, "mid-frame reset ready", int'(a_ready), 1);
    chk(0, "mid-frame reset done", int'(a_done), 0);
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    w = 0;
    repeat (6) begin
      @(negedge clk);
      w += int'(a_done !== 1'b0);
    end
    chk(0, "done after abort", w, 0);
    send(0, 'hC6, 2'b01, 1'b0, 1'b0);

    send(1, 'h7F, 2'b10, 1'b0, 1'b0);
    send(1, 'h2A, 2'b01, 1'b1, 1'b0);
    send(1, int'($urandom_range(0, 127)), int'($urandom_range(0, 3)), 1'b0, 1'b1);
    send(1, int'($urandom_range(0, 127)), int'($urandom_range(0, 3)), 1'b0, 1'b0);

    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((q0.size() != 0 || q1.size() != 0 || mon_act[0] != 0 || mon_act[1] != 0)
               && w < 2000);
    chk(0, "drain pending frames", q0.size() + q1.size() + mon_act[0] + mon_act[1], 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
